// File: rtl/bpsk_mod.sv
// BPSK modulator.
// Serializes bytes MSB-first and holds each bit for SAMPLES_PER_BIT carrier
// samples. A 1 bit passes the carrier through unchanged. A 0 bit sends the
// bitwise complement of the carrier, which mirrors the sample around the
// offset-binary midpoint. The registered output feeds the transmitter DAC path.
module bpsk_mod #(
  parameter int DATA_WIDTH      = 12,
  parameter int BYTE_WIDTH      = 8,
  parameter int SAMPLES_PER_BIT = 256
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [DATA_WIDTH-1:0] carrier_in,
  input  logic [BYTE_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] mod_out,
  output logic                  busy,
  output logic                  done
);

  localparam int SCW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int BCW = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;

  localparam logic [SCW-1:0]        SAMPLE_LAST = SCW'(SAMPLES_PER_BIT - 1);
  localparam logic [BCW-1:0]        BIT_LAST    = BCW'(BYTE_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIDPOINT    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    TX   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [BYTE_WIDTH-1:0] shift_q, shift_d;
  logic [SCW-1:0]        sample_cnt_q, sample_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] mod_out_q, mod_out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic sample_last;
  logic byte_last;
  logic xfer;

  // Decode the final sample of the final bit; this opens the ready window
  // that allows a new byte to follow without a gap.
  always_comb begin
    sample_last = (sample_cnt_q == SAMPLE_LAST);
    byte_last   = (state_q == TX) && sample_last && (bit_cnt_q == BIT_LAST);
    s_ready     = (state_q == IDLE) || byte_last;
    xfer        = s_valid && s_ready;
  end

  // Next-state, counter, shifter and output-sample logic.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    mod_out_d    = MIDPOINT;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          shift_d      = s_data;
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
          state_d      = TX;
        end
      end

      TX: begin
        mod_out_d = shift_q[BYTE_WIDTH-1] ? carrier_in : ~carrier_in;
        if (sample_last) begin
          sample_cnt_d = '0;
          shift_d      = shift_q << 1;
          bit_cnt_d    = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BIT_LAST) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            if (xfer) begin
              shift_d = s_data;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          sample_cnt_d = sample_cnt_q + SCW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == TX);
  end

  // State and datapath registers with synchronous reset; reset aborts any
  // byte in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      mod_out_q    <= MIDPOINT;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      mod_out_q    <= mod_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mod_out = mod_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bpsk_mod.sv
// Testbench for bpsk_mod (SAMPLES_PER_BIT = 4).
// The stimulus side keeps a transaction-level model. It tracks how many modulated
// samples remain, and on each accepted byte it queues one expected entry per output
// sample. A negedge monitor pops an entry whenever the DUT was busy before the last
// edge, and checks every output each cycle.
module tb_bpsk_mod;

  localparam int DW    = 12;
  localparam int BW    = 8;
  localparam int SPB   = 4;
  localparam int TOTAL = BW * SPB;
  localparam logic [DW-1:0] MID = 12'h800;
  localparam int HMASK = 16383;

  logic          clk;
  logic          arst;
  logic [DW-1:0] carrier_in;
  logic [BW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] mod_out;
  logic          busy;
  logic          done;

  bpsk_mod #(
    .DATA_WIDTH(DW),
    .BYTE_WIDTH(BW),
    .SAMPLES_PER_BIT(SPB)
  ) dut (
    .clk(clk),
    .arst(arst),
    .carrier_in(carrier_in),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .mod_out(mod_out),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic bit_val;
    int   idx;
    logic last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] carr_hist [0:HMASK];
  int            cyc;
  int            rem;
  int            checks;
  int            errors;
  int            done_seen;
  int            done_exp;
  int            carrier_mode;
  logic [DW-1:0] ramp;
  logic          mon_en;
  logic          last_busy;
  logic          last_arst;

  exp_t          mon_e;
  logic [DW-1:0] mon_v;
  logic [DW-1:0] mon_exp_mod;
  logic          mon_exp_done;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  // Advance one clock. At the edge the model sees the inputs that were applied
  // before it. After the edge the next carrier sample is driven.
  task automatic applyStimulus();
    exp_t e;
    logic [DW-1:0] v;
    @(posedge clk);
    cyc++;
    if (arst) begin
      rem = 0;
      exp_q.delete();
    end else begin
      if (rem == 1) done_exp++;
      if (s_valid && rem <= 1) begin
        for (int k = 0; k < TOTAL; k++) begin
          e.bit_val = s_data[BW - 1 - (k / SPB)];
          e.idx     = cyc + 1 + k;
          e.last    = (k == TOTAL - 1);
          exp_q.push_back(e);
        end
        rem = TOTAL;
      end else if (rem > 0) begin
        rem--;
      end
    end
    #1;
    case (carrier_mode)
      1: begin
        v    = ramp;
        ramp = ramp + 12'h001;
      end
      2: begin
        case (cyc % 3)
          0:       v = 12'h000;
          1:       v = 12'h800;
          default: v = 12'hFFF;
        endcase
      end
      default: v = DW'($urandom);
    endcase
    carr_hist[(cyc + 1) & HMASK] = v;
    carrier_in = v;
  endtask

  // Offer a byte and hold it until the model says the DUT is ready.
  task automatic sendByte(input logic [BW-1:0] b, input logic keep_valid);
    s_data  = b;
    s_valid = 1'b1;
    for (int i = 0; i < 100 && rem > 1; i++) applyStimulus();
    if (rem > 1) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_wait: got rem %0d, required <=1", rem);
    end
    applyStimulus();
    if (!keep_valid) s_valid = 1'b0;
  endtask

  // Run until the model reports idle, then a few extra cycles.
  task automatic drain();
    for (int i = 0; i < 200 && rem != 0; i++) applyStimulus();
    repeat (2) applyStimulus();
  endtask

  // Monitor: one expected sample per cycle the DUT was transmitting before the
  // edge; midpoint and no done otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp_mod  = MID;
      mon_exp_done = 1'b0;
      if (last_busy === 1'b1 && last_arst === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_underflow at cycle %0d: got empty queue, required an entry", cyc);
        end else begin
          mon_e        = exp_q.pop_front();
          mon_v        = carr_hist[mon_e.idx & HMASK];
          mon_exp_mod  = mon_e.bit_val ? mon_v : ~mon_v;
          mon_exp_done = mon_e.last;
        end
      end
      checkOutput("mod_out", 32'(mod_out), 32'(mon_exp_mod));
      checkOutput("done", 32'(done), 32'(mon_exp_done));
      checkOutput("busy", 32'(busy), 32'(rem > 0));
      checkOutput("s_ready", 32'(s_ready), 32'(rem <= 1));
      if (done === 1'b1) done_seen++;
    end
    last_busy = busy;
    last_arst = arst;
  end

  initial begin
    arst         = 1'b1;
    s_valid      = 1'b0;
    s_data       = '0;
    carrier_in   = '0;
    carrier_mode = 0;
    ramp         = 12'h120;
    rem          = 0;
    cyc          = 0;
    checks       = 0;
    errors       = 0;
    done_seen    = 0;
    done_exp     = 0;
    mon_en       = 1'b0;
    last_busy    = 1'b0;
    last_arst    = 1'b1;

    // Reset for two cycles, then idle; reset again while idle.
    applyStimulus();
    mon_en = 1'b1;
    applyStimulus();
    arst = 1'b0;
    repeat (3) applyStimulus();
    arst = 1'b1;
    repeat (2) applyStimulus();
    arst = 1'b0;
    repeat (2) applyStimulus();

    // Single byte over a counting-ramp carrier.
    carrier_mode = 1;
    sendByte(8'hA5, 1'b0);
    drain();

    // Back-to-back bytes with valid held high.
    carrier_mode = 0;
    sendByte(8'hFF, 1'b1);
    sendByte(8'h00, 1'b0);
    drain();

    // Reset in the middle of a byte, then a clean byte.
    sendByte(8'hB7, 1'b0);
    repeat (9) applyStimulus();
    arst = 1'b1;
    applyStimulus();
    arst = 1'b0;
    applyStimulus();
    sendByte(8'h5A, 1'b0);
    drain();

    // New byte offered during transmission must wait for the ready window.
    sendByte(8'hC3, 1'b0);
    repeat (5) applyStimulus();
    sendByte(8'h3C, 1'b0);
    drain();

    // Carrier extremes through both bit values.
    carrier_mode = 2;
    sendByte(8'h0F, 1'b1);
    sendByte(8'hF0, 1'b0);
    drain();

    // Random bytes with random gaps and occasional back-to-back.
    carrier_mode = 0;
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) applyStimulus();
      sendByte(BW'($urandom), 1'($urandom_range(0, 1)));
    end
    s_valid = 1'b0;
    drain();

    checkOutput("done_count", 32'(done_seen), 32'(done_exp));
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
